// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode with register-file write-through bypass,
// load-use stall detection and the ID/EX pipeline register.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     Instr_ID,
    input  logic [31:0]     PC_ID,
    input  logic            Valid_ID,
    input  logic            Flush_ID,
    output logic [4:0]      RAddr1_RF,
    output logic [4:0]      RAddr2_RF,
    input  logic [XLEN-1:0] RD1_RF,
    input  logic [XLEN-1:0] RD2_RF,
    input  logic            WrEn_RF,
    input  logic [4:0]      WAddr_RF,
    input  logic [XLEN-1:0] WD_RF,
    output logic            Stall_ID,
    output logic            Valid_EX,
    output logic [31:0]     PC_EX,
    output logic [XLEN-1:0] Rs1Val_EX,
    output logic [XLEN-1:0] Rs2Val_EX,
    output logic [XLEN-1:0] Imm_EX,
    output logic [4:0]      Rd_EX,
    output logic [6:0]      Opcode_EX,
    output logic [2:0]      Funct3_EX,
    output logic            Funct7b5_EX,
    output logic            RegWrite_EX,
    output logic            MemRead_EX,
    output logic            MemWrite_EX,
    output logic            Illegal_EX
);
    logic [6:0] opcode;
    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
    logic uses_rs1, uses_rs2, reg_write_d, illegal_d, bubble;
    logic [4:0] rd_d;
    logic [XLEN-1:0] imm_d, rs1_val_d, rs2_val_d;
    logic valid_q, f7b5_q, reg_write_q, mem_read_q, mem_write_q, illegal_q;
    logic [31:0] pc_q;
    logic [XLEN-1:0] rs1_val_q, rs2_val_q, imm_q;
    logic [4:0] rd_q;
    logic [6:0] opcode_q;
    logic [2:0] funct3_q;

    assign opcode    = Instr_ID[6:0];
    assign is_lui    = opcode == 7'b0110111;
    assign is_auipc  = opcode == 7'b0010111;
    assign is_jal    = opcode == 7'b1101111;
    assign is_jalr   = opcode == 7'b1100111;
    assign is_branch = opcode == 7'b1100011;
    assign is_load   = opcode == 7'b0000011;
    assign is_store  = opcode == 7'b0100011;
    assign is_opimm  = opcode == 7'b0010011;
    assign is_op     = opcode == 7'b0110011;

    assign illegal_d   = !(is_lui || is_auipc || is_jal || is_jalr || is_branch ||
                           is_load || is_store || is_opimm || is_op);
    assign reg_write_d = is_lui || is_auipc || is_jal || is_jalr || is_load || is_opimm || is_op;
    assign uses_rs1    = is_jalr || is_branch || is_load || is_store || is_opimm || is_op;
    assign uses_rs2    = is_branch || is_store || is_op;
    assign rd_d        = reg_write_d ? Instr_ID[11:7] : 5'd0;

    assign imm_d = (is_load || is_opimm || is_jalr) ? {{20{Instr_ID[31]}}, Instr_ID[31:20]} :
                   is_store  ? {{20{Instr_ID[31]}}, Instr_ID[31:25], Instr_ID[11:7]} :
                   is_branch ? {{19{Instr_ID[31]}}, Instr_ID[31], Instr_ID[7], Instr_ID[30:25],
                                Instr_ID[11:8], 1'b0} :
                   (is_lui || is_auipc) ? {Instr_ID[31:12], 12'b0} :
                   is_jal    ? {{11{Instr_ID[31]}}, Instr_ID[31], Instr_ID[19:12], Instr_ID[20],
                                Instr_ID[30:21], 1'b0} : '0;

    assign RAddr1_RF = Instr_ID[19:15];
    assign RAddr2_RF = Instr_ID[24:20];

    // The register file commits WD_RF on the same edge we capture, so bypass it here.
    assign rs1_val_d = (RAddr1_RF == 5'd0) ? '0 :
                       (WrEn_RF && WAddr_RF == RAddr1_RF) ? WD_RF : RD1_RF;
    assign rs2_val_d = (RAddr2_RF == 5'd0) ? '0 :
                       (WrEn_RF && WAddr_RF == RAddr2_RF) ? WD_RF : RD2_RF;

    assign Stall_ID = Valid_ID && valid_q && mem_read_q && rd_q != 5'd0 &&
                      ((uses_rs1 && RAddr1_RF == rd_q) || (uses_rs2 && RAddr2_RF == rd_q)) &&
                      !Flush_ID;
    assign bubble   = rst || Flush_ID || Stall_ID || !Valid_ID;

    always_ff @(posedge clk) begin
        if (bubble) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            imm_q       <= '0;
            rd_q        <= '0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            f7b5_q      <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            valid_q     <= 1'b1;
            pc_q        <= PC_ID;
            rs1_val_q   <= rs1_val_d;
            rs2_val_q   <= rs2_val_d;
            imm_q       <= imm_d;
            rd_q        <= rd_d;
            opcode_q    <= opcode;
            funct3_q    <= Instr_ID[14:12];
            f7b5_q      <= Instr_ID[30];
            reg_write_q <= reg_write_d;
            mem_read_q  <= is_load;
            mem_write_q <= is_store;
            illegal_q   <= illegal_d;
        end
    end

    assign Valid_EX    = valid_q;
    assign PC_EX       = pc_q;
    assign Rs1Val_EX   = rs1_val_q;
    assign Rs2Val_EX   = rs2_val_q;
    assign Imm_EX      = imm_q;
    assign Rd_EX       = rd_q;
    assign Opcode_EX   = opcode_q;
    assign Funct3_EX   = funct3_q;
    assign Funct7b5_EX = f7b5_q;
    assign RegWrite_EX = reg_write_q;
    assign MemRead_EX  = mem_read_q;
    assign MemWrite_EX = mem_write_q;
    assign Illegal_EX  = illegal_q;
endmodule
